// File: rtl/pipeline_rr_scheduler_pkg.sv
// Shared types for the two-requester pipeline scheduler: FSM states, requester count and the
// in-flight tag carried alongside each operation.
package pipeline_rr_scheduler_pkg;

  localparam int unsigned NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

endpackage

// File: rtl/pipeline_rr_scheduler_rr_arbiter2.sv
// Two-way round-robin selector: the requester after last_grant wins a tie, a lone requester
// always wins.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant
);

  always_comb begin
    grant_valid = |req;
    grant       = 1'b0;
    unique case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/pipeline_rr_scheduler.sv
// Feeds an external fixed-latency pipeline from two requesters and routes each result back to
// its owner using a tag shift register that tracks the pipeline's occupancy.
module pipeline_rr_scheduler
  import pipeline_rr_scheduler_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned PIPE_DEPTH = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              req0_valid,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req0_x,
  input  logic [DATA_W-1:0] req1_x,
  output logic              req0_ready,
  output logic              req1_ready,
  output logic              pipe_input_valid,
  output logic [DATA_W-1:0] pipe_x,
  output logic              pipe_rst,
  input  logic              pipe_output_valid,
  input  logic [DATA_W-1:0] pipe_out,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              idle,
  output logic [1:0]        inflight,
  output logic              err
);

  state_e                r_state;
  state_e                w_state_next;
  tag_t [PIPE_DEPTH-1:0] r_tags;
  tag_t                  w_tag_in;
  tag_t                  w_tag_last;
  logic                  r_last_grant;
  logic                  r_err;
  logic [1:0]            r_inflight;
  logic [1:0]            w_inflight_next;
  logic [NUM_REQ-1:0]    w_req;
  logic                  w_grant_valid;
  logic                  w_grant;
  logic                  w_issue;
  logic                  w_tags_pending;

  assign w_req = {req1_valid, req0_valid};

  rr_arbiter2 u_arb (
    .req         (w_req),
    .last_grant  (r_last_grant),
    .grant_valid (w_grant_valid),
    .grant       (w_grant)
  );

  assign w_issue    = (r_state == RUN) && w_grant_valid;
  assign w_tag_in   = tag_t'({w_issue, w_grant});
  assign w_tag_last = r_tags[PIPE_DEPTH-1];

  assign req0_ready       = w_issue && !w_grant;
  assign req1_ready       = w_issue && w_grant;
  assign pipe_input_valid = w_issue;
  assign pipe_x           = w_issue ? (w_grant ? req1_x : req0_x) : '0;
  // Pipeline clears in the same edge as this block so no stale result can surface.
  assign pipe_rst         = !rst_n;

  assign rsp0_valid = pipe_output_valid && w_tag_last.valid && !w_tag_last.id;
  assign rsp1_valid = pipe_output_valid && w_tag_last.valid && w_tag_last.id;
  assign rsp_data   = pipe_out;

  assign idle     = (r_state == IDLE);
  assign inflight = r_inflight;
  assign err      = r_err;

  // Occupancy the tag register will hold after this edge; the last entry always shifts out.
  always_comb begin
    w_tags_pending = w_issue;
    for (int i = 0; i < PIPE_DEPTH - 1; i++) begin
      w_tags_pending = w_tags_pending | r_tags[i].valid;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (en) w_state_next = RUN;
      RUN:     if (!en) w_state_next = DRAIN;
      DRAIN: begin
        if (en) begin
          w_state_next = RUN;
        end else if (!w_tags_pending) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_inflight_next = r_inflight;
    unique case ({w_issue, w_tag_last.valid})
      2'b10:   w_inflight_next = r_inflight + 2'd1;
      2'b01:   w_inflight_next = r_inflight - 2'd1;
      default: w_inflight_next = r_inflight;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_tags       <= '0;
      r_last_grant <= 1'b1;
      r_err        <= 1'b0;
      r_inflight   <= 2'd0;
    end else begin
      r_state    <= w_state_next;
      r_tags     <= {r_tags[PIPE_DEPTH-2:0], w_tag_in};
      r_inflight <= w_inflight_next;
      if (w_issue) begin
        r_last_grant <= w_grant;
      end
      if (pipe_output_valid != w_tag_last.valid) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_rr_scheduler.sv
// Bench for pipeline_rr_scheduler: a model x+1 pipeline, a vector table, directed corner cases
// and a randomized run against a queue-based reference model.
module tb_pipeline_rr_scheduler;

  localparam int DW = 32;
  localparam int PD = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          req0_valid;
  logic          req1_valid;
  logic [DW-1:0] req0_x;
  logic [DW-1:0] req1_x;
  logic          req0_ready;
  logic          req1_ready;
  logic          pipe_input_valid;
  logic [DW-1:0] pipe_x;
  logic          pipe_rst;
  logic          pipe_output_valid;
  logic [DW-1:0] pipe_out;
  logic          rsp0_valid;
  logic          rsp1_valid;
  logic [DW-1:0] rsp_data;
  logic          idle;
  logic [1:0]    inflight;
  logic          err;
  logic          inject;

  always #5 clk = ~clk;

  pipeline_rr_scheduler #(
    .DATA_W     (DW),
    .PIPE_DEPTH (PD)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .en                (en),
    .req0_valid        (req0_valid),
    .req1_valid        (req1_valid),
    .req0_x            (req0_x),
    .req1_x            (req1_x),
    .req0_ready        (req0_ready),
    .req1_ready        (req1_ready),
    .pipe_input_valid  (pipe_input_valid),
    .pipe_x            (pipe_x),
    .pipe_rst          (pipe_rst),
    .pipe_output_valid (pipe_output_valid),
    .pipe_out          (pipe_out),
    .rsp0_valid        (rsp0_valid),
    .rsp1_valid        (rsp1_valid),
    .rsp_data          (rsp_data),
    .idle              (idle),
    .inflight          (inflight),
    .err               (err)
  );

  // Model of the external pipeline: result = x + 1, PD cycles after input_valid.
  logic [PD-1:0] pv;
  logic [DW-1:0] pd [PD];

  always @(posedge clk) begin
    if (pipe_rst) begin
      pv <= '0;
      for (int i = 0; i < PD; i++) pd[i] <= '0;
    end else begin
      pv    <= {pv[PD-2:0], pipe_input_valid};
      pd[0] <= pipe_x + 32'd1;
      for (int i = 1; i < PD; i++) pd[i] <= pd[i-1];
    end
  end

  assign pipe_output_valid = pv[PD-1] | inject;
  assign pipe_out          = pd[PD-1];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called just after a falling edge; leaves 1 time unit for combinational outputs to settle.
  task automatic drive(input logic r, input logic e, input logic v0, input logic v1,
                       input logic [DW-1:0] a, input logic [DW-1:0] b, input logic inj);
    rst_n      = r;
    en         = e;
    req0_valid = v0;
    req1_valid = v1;
    req0_x     = a;
    req1_x     = b;
    inject     = inj;
    #1;
  endtask

  typedef struct {
    logic          rst;
    logic          e;
    logic          v0;
    logic          v1;
    logic [DW-1:0] x0;
    logic [DW-1:0] x1;
    logic          chk;
    logic          r0;
    logic          r1;
    logic          idl;
    logic [1:0]    inf;
    logic          s0;
    logic          s1;
    logic [DW-1:0] d;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic e, logic v0, logic v1, logic [DW-1:0] x0,
                              logic [DW-1:0] x1, logic chk, logic r0, logic r1, logic idl,
                              logic [1:0] inf, logic s0, logic s1, logic [DW-1:0] d);
    vec_t v;
    v.rst = rst; v.e = e; v.v0 = v0; v.v1 = v1; v.x0 = x0; v.x1 = x1; v.chk = chk;
    v.r0 = r0; v.r1 = r1; v.idl = idl; v.inf = inf; v.s0 = s0; v.s1 = s1; v.d = d;
    return v;
  endfunction

  typedef struct {
    int            id;
    logic [DW-1:0] data;
    int            due;
  } op_t;

  op_t           q[$];
  int            mode;
  int            last;
  int            cyc;
  logic          merr;

  initial begin
    rst_n = 1'b0; en = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_x = '0; req1_x = '0; inject = 1'b0;
    @(negedge clk);

    // Single request, then continuous contention into a drain.
    tbl.push_back(mk(0, 0, 0, 0, 0,  0,  0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 5,  0,  1, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 5,  0,  1, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0,  0,  1, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0,  0,  1, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0,  0,  1, 0, 0, 0, 1, 1, 0, 6));
    tbl.push_back(mk(1, 1, 0, 0, 0,  0,  1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,  0,  0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1, 10, 20, 1, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1, 10, 20, 1, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1, 10, 20, 1, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1, 10, 20, 1, 1, 0, 0, 2, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1, 10, 20, 1, 0, 1, 0, 3, 1, 0, 11));
    tbl.push_back(mk(1, 1, 1, 1, 10, 20, 1, 1, 0, 0, 3, 0, 1, 21));
    tbl.push_back(mk(1, 1, 1, 1, 10, 20, 1, 0, 1, 0, 3, 1, 0, 11));
    tbl.push_back(mk(1, 0, 1, 1, 10, 20, 1, 1, 0, 0, 3, 0, 1, 21));
    tbl.push_back(mk(1, 0, 1, 1, 10, 20, 1, 0, 0, 0, 3, 1, 0, 11));
    tbl.push_back(mk(1, 0, 1, 1, 10, 20, 1, 0, 0, 0, 2, 0, 1, 21));
    tbl.push_back(mk(1, 0, 1, 1, 10, 20, 1, 0, 0, 0, 1, 1, 0, 11));
    tbl.push_back(mk(1, 0, 1, 1, 10, 20, 1, 0, 0, 1, 0, 0, 0, 0));

    foreach (tbl[k]) begin
      drive(tbl[k].rst, tbl[k].e, tbl[k].v0, tbl[k].v1, tbl[k].x0, tbl[k].x1, 1'b0);
      if (tbl[k].chk) begin
        check($sformatf("row%0d_ready0", k), req0_ready, tbl[k].r0);
        check($sformatf("row%0d_ready1", k), req1_ready, tbl[k].r1);
        check($sformatf("row%0d_idle", k), idle, tbl[k].idl);
        check($sformatf("row%0d_inflight", k), inflight, tbl[k].inf);
        check($sformatf("row%0d_rsp0", k), rsp0_valid, tbl[k].s0);
        check($sformatf("row%0d_rsp1", k), rsp1_valid, tbl[k].s1);
        check($sformatf("row%0d_err", k), err, 1'b0);
        if (tbl[k].s0 || tbl[k].s1) check($sformatf("row%0d_data", k), rsp_data, tbl[k].d);
      end
      @(negedge clk);
    end

    // Reset with two operations in flight discards them silently.
    drive(0, 0, 0, 0, 0, 0, 0); @(negedge clk);
    drive(1, 1, 1, 0, 3, 0, 0); check("rst_mid_idle0", idle, 1'b1); @(negedge clk);
    drive(1, 1, 1, 0, 3, 0, 0); check("rst_mid_rdy_a", req0_ready, 1'b1); @(negedge clk);
    drive(1, 1, 1, 0, 4, 0, 0); check("rst_mid_rdy_b", req0_ready, 1'b1); @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0); check("rst_mid_piperst", pipe_rst, 1'b1);
    check("rst_mid_infl2", inflight, 2'd2); @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0);
      check("rst_mid_rsp0", rsp0_valid, 1'b0);
      check("rst_mid_rsp1", rsp1_valid, 1'b0);
      check("rst_mid_infl", inflight, 2'd0);
      check("rst_mid_idle", idle, 1'b1);
      check("rst_mid_err", err, 1'b0);
      @(negedge clk);
    end

    // Spurious pipeline valid with no tag sets a sticky error.
    drive(1, 0, 0, 0, 0, 0, 1);
    check("spur_rsp0", rsp0_valid, 1'b0);
    check("spur_rsp1", rsp1_valid, 1'b0);
    check("spur_err_pre", err, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 1, 1, 1, 2, 0);
      check("spur_err_sticky", err, 1'b1);
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 0, 0, 0); check("spur_err_inrst", err, 1'b1); @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0); check("spur_err_clr", err, 1'b0); @(negedge clk);

    // en falls in the same cycle as a request: it still issues, then drains.
    drive(1, 1, 0, 0, 0, 0, 0); check("late_idle0", idle, 1'b1); @(negedge clk);
    drive(1, 0, 0, 1, 0, 7, 0);
    check("late_rdy1", req1_ready, 1'b1);
    check("late_rdy0", req0_ready, 1'b0);
    check("late_px", pipe_x, 32'd7);
    @(negedge clk);
    drive(1, 0, 0, 1, 0, 7, 0);
    check("late_drain_rdy", req1_ready, 1'b0);
    check("late_drain_idle", idle, 1'b0);
    check("late_infl", inflight, 2'd1);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0); check("late_idle_mid", idle, 1'b0); @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0);
    check("late_rsp1", rsp1_valid, 1'b1);
    check("late_rsp0", rsp0_valid, 1'b0);
    check("late_data", rsp_data, 32'd8);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0); check("late_idle_end", idle, 1'b1);
    check("late_infl_end", inflight, 2'd0); @(negedge clk);

    // Randomized run against a queue-of-operations reference model.
    mode = 0; last = 1; cyc = 0; merr = 1'b0;
    for (int i = 0; i < 800; i++) begin
      logic          r;
      logic          e;
      logic          v0;
      logic          v1;
      logic          inj;
      logic          ret;
      logic          pov;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [DW-1:0] ex;
      int            win;
      r   = (i == 0) ? 1'b0 : ($urandom_range(0, 59) != 0);
      e   = ($urandom_range(0, 9) < 7);
      v0  = ($urandom_range(0, 3) != 0);
      v1  = ($urandom_range(0, 3) != 0);
      inj = ($urandom_range(0, 99) == 0);
      a   = $urandom;
      b   = $urandom;
      drive(r, e, v0, v1, a, b, inj);

      win = -1;
      if (mode == 1) begin
        if (v0 && v1) win = 1 - last;
        else if (v0)  win = 0;
        else if (v1)  win = 1;
      end
      ret = (q.size() > 0) && (q[0].due == cyc);
      pov = ret || inj;
      ex  = (win == 0) ? a : ((win == 1) ? b : '0);

      check("rnd_ready0", req0_ready, win == 0);
      check("rnd_ready1", req1_ready, win == 1);
      check("rnd_piv", pipe_input_valid, win >= 0);
      check("rnd_px", pipe_x, ex);
      check("rnd_rsp0", rsp0_valid, pov && ret && q[0].id == 0);
      check("rnd_rsp1", rsp1_valid, pov && ret && q[0].id == 1);
      if (ret) check("rnd_data", rsp_data, q[0].data + 32'd1);
      check("rnd_idle", idle, mode == 0);
      check("rnd_infl", inflight, q.size());
      check("rnd_err", err, merr);
      check("rnd_piperst", pipe_rst, !r);

      if (!r) begin
        mode = 0; last = 1; merr = 1'b0;
        q.delete();
      end else begin
        if (pov != ret) merr = 1'b1;
        if (ret) void'(q.pop_front());
        if (win >= 0) begin
          q.push_back('{id: win, data: ex, due: cyc + PD});
          last = win;
        end
        case (mode)
          0:       if (e) mode = 1;
          1:       if (!e) mode = 2;
          default: begin
            if (e) mode = 1;
            else if (q.size() == 0) mode = 0;
          end
        endcase
      end
      cyc++;
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_rr_scheduler.md
PIPELINE_RR_SCHEDULER -- requirements
Module: pipeline_rr_scheduler

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the request/response data width.
REQ-002 The block SHALL have parameter PIPE_DEPTH, default 3, giving the cycles from pipe_input_valid to pipe_output_valid (for 2 stages: p0 + 2 stage registers).
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 The block SHALL have port en  input  1  scheduler enable; 0 requests drain.
REQ-006 The block SHALL have ports req0_valid, req1_valid  input  1  requester has an operand.
REQ-007 The block SHALL have ports req0_x, req1_x  input  DATA_W  requester operands.
REQ-008 The block SHALL have ports req0_ready, req1_ready  output  1  operand accepted this cycle.
REQ-009 The block SHALL have ports pipe_input_valid (output, 1), pipe_x (output, DATA_W) and pipe_rst (output, 1), which drive the pipeline's input_valid, x and active-high rst.
REQ-010 The block SHALL have ports pipe_output_valid (input, 1) and pipe_out (input, DATA_W), driven from the pipeline outputs.
REQ-011 The block SHALL have ports rsp0_valid, rsp1_valid  output  1  result for that requester; rsp_data  output  DATA_W  shared result bus.
REQ-012 The block SHALL have ports idle  output  1  FSM in IDLE; inflight  output  2  operations in pipeline; err  output  1  sticky tag/valid mismatch.

Function
REQ-013 FSM states SHALL be IDLE, RUN and DRAIN; transitions IDLE->RUN when en=1; RUN->DRAIN when en=0; DRAIN->RUN when en=1; DRAIN->IDLE when en=0 and no tag valid after the update.
REQ-014 Grants SHALL occur only in RUN; issue = RUN and req_valid of the granted requester; reqN_ready = issue and grant==N, one-hot or zero.
REQ-015 Arbitration SHALL be round-robin: the requester after last_grant has priority; a lone valid requester wins regardless; last_grant updates only on issue.
REQ-016 pipe_input_valid SHALL equal issue combinationally; pipe_x SHALL be the granted req_x when issuing, else 0.
REQ-017 A PIPE_DEPTH-entry tag shift register {valid, id} SHALL advance every cycle; entry 0 loads {issue, grant}.
REQ-018 rspN_valid SHALL be pipe_output_valid and last-entry valid and id==N; rsp_data SHALL equal pipe_out combinationally; there is no backpressure on responses.
REQ-019 err SHALL set when pipe_output_valid differs from last-entry valid and hold until reset.
REQ-020 inflight SHALL count valid tag entries, range 0..3; issue and retire in the same cycle leave it unchanged.
REQ-021 en falling in the same cycle as a request SHALL still let that request issue, because state is RUN that cycle; DRAIN issues nothing.
REQ-022 Both requesters valid every cycle SHALL give strict alternation; requester 0 wins the first grant after reset.

Reset
REQ-023 With rst_n=0 at a clock edge: state IDLE, tags cleared, last_grant=1, err=0; thus ready=0, pipe_input_valid=0, rsp*_valid=0, inflight=0, idle=1.
REQ-024 pipe_rst SHALL equal !rst_n combinationally, so the pipeline's valids clear in the same cycle; reset mid-operation discards in-flight results with no response and no err.

Structure
REQ-025 Package pipeline_rr_scheduler_pkg SHALL hold the state enum (IDLE/RUN/DRAIN), NUM_REQ=2 and the tag struct {valid, id}.
REQ-026 Round-robin selection SHALL be sub-module rr_arbiter2 (inputs req[1:0], last_grant; outputs grant_valid, grant); the FSM, tags and counters stay in the top.

Verification
REQ-027 After reset, en=1, req0_valid only, req0_x=5 -> req0_ready next cycle; rsp0_valid 3 cycles later with rsp_data=6.
REQ-028 Both requesters valid continuously, x0=10, x1=20 -> grants 0,1,0,1; responses alternate rsp0(11)/rsp1(21) back-to-back; inflight reaches 3 and holds.
REQ-029 Three operations in flight, then en=0 -> no further ready; state DRAIN for 3 cycles; all 3 responses delivered; idle=1 on the cycle after the last retire.
REQ-030 rst_n=0 for one cycle with 2 in flight -> no rsp*_valid afterward; inflight=0; idle=1; err=0.
REQ-031 Inject a spurious pipe_output_valid with no tag -> err=1, no rsp*_valid, and err stays 1 until rst_n=0.
REQ-032 en dropped in the same cycle req1_valid=1 with x1=7 -> request issues, state becomes DRAIN; rsp1 carries 8, then idle.
